// File: rtl/io_bus_pkg.sv
// Shared constants, FSM state encoding and IO address decode for the io_bus_ctrl slice.
package io_bus_pkg;

    localparam logic [21:0] IO_BASE_HI_DEF = 22'h3FFFFF;
    localparam logic [31:0] LED_ADDR       = 32'hFFFF_FC60;
    localparam logic [31:0] SW_ADDR        = 32'hFFFF_FC62;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MEM_ISSUE,
        ST_MEM_WAIT,
        ST_IO_ACCESS,
        ST_DONE
    } state_t;

    typedef enum logic [1:0] {
        IO_NONE,
        IO_LED,
        IO_SW
    } io_sel_t;

    // Offset decode inside the 1 KiB IO window; the window itself is matched on addr[31:10].
    function automatic io_sel_t io_decode(input logic [9:0] offs);
        if (offs == LED_ADDR[9:0]) begin
            return IO_LED;
        end
        if (offs == SW_ADDR[9:0]) begin
            return IO_SW;
        end
        return IO_NONE;
    endfunction

endpackage

// File: rtl/io_bus_if.sv
// CPU-side request/ack bus and memory-side strobe bus, each with master/slave views.
interface io_cpu_if;
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_ack;
    logic        cpu_stall;

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_ack, cpu_stall
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_ack, cpu_stall
    );
endinterface

interface io_mem_if;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport master (
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport slave (
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/io_sync2.sv
// Two-flop synchroniser for asynchronous level inputs, synchronous active-high reset.
module io_sync2 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/io_bus_ctrl.sv
// CPU bus bridge: routes each request to a fixed-latency memory port or to the LED/switch IO block.
//  state        | meaning
//  ST_IDLE      | waiting for cpu_req, latches the access on acceptance
//  ST_MEM_ISSUE | single-cycle mem_en strobe
//  ST_MEM_WAIT  | read latency countdown, captures mem_rdata at count 1
//  ST_IO_ACCESS | LED/switch access or unmapped-address error
//  ST_DONE      | one-cycle cpu_ack
module io_bus_ctrl
    import io_bus_pkg::*;
#(
    parameter int          MEM_LATENCY = 1,
    parameter logic [21:0] IO_BASE_HI  = IO_BASE_HI_DEF
) (
    input  logic        clk,
    input  logic        rst,
    io_cpu_if.slave     cpu,
    io_mem_if.master    mem,
    input  logic [15:0] sw_in,
    output logic [15:0] led_out,
    output logic        bus_err
);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic [15:0] led_q, led_d;
    logic        err_q, err_d;
    logic [15:0] sw_sync;
    io_sel_t     io_sel;
    logic        req_is_io;

    io_sync2 #(.WIDTH(16)) u_sw_sync (
        .clk (clk),
        .rst (rst),
        .d_i (sw_in),
        .q_o (sw_sync)
    );

    assign req_is_io = (cpu.cpu_addr[31:10] == IO_BASE_HI);
    assign io_sel    = io_decode(addr_q[9:0]);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (cpu.cpu_req) begin
                    state_d = req_is_io ? ST_IO_ACCESS : ST_MEM_ISSUE;
                end
            end
            ST_MEM_ISSUE: state_d = we_q ? ST_DONE : ST_MEM_WAIT;
            ST_MEM_WAIT: begin
                if (cnt_q <= 4'd1) begin
                    state_d = ST_DONE;
                end
            end
            ST_IO_ACCESS: state_d = ST_DONE;
            ST_DONE:      state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        mem.mem_en  = 1'b0;
        mem.mem_we  = 1'b0;
        cpu.cpu_ack = 1'b0;
        case (state_q)
            ST_MEM_ISSUE: begin
                mem.mem_en = 1'b1;
                mem.mem_we = we_q;
            end
            ST_DONE: cpu.cpu_ack = 1'b1;
            default: ;
        endcase
    end

    // Datapath next-state; the access fields are frozen from acceptance to the next acceptance.
    always_comb begin
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        led_d   = led_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (cpu.cpu_req) begin
                    we_d    = cpu.cpu_we;
                    addr_d  = cpu.cpu_addr;
                    wdata_d = cpu.cpu_wdata;
                end
            end
            ST_MEM_ISSUE: begin
                if (!we_q) begin
                    cnt_d = 4'(MEM_LATENCY);
                end
            end
            ST_MEM_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    rdata_d = mem.mem_rdata;
                end
            end
            ST_IO_ACCESS: begin
                case (io_sel)
                    IO_LED: begin
                        if (we_q) begin
                            led_d = wdata_q[15:0];
                        end else begin
                            rdata_d = {16'h0000, led_q};
                        end
                    end
                    IO_SW: begin
                        if (!we_q) begin
                            rdata_d = {16'h0000, sw_sync};
                        end
                    end
                    default: begin
                        err_d = 1'b1;
                        if (!we_q) begin
                            rdata_d = '0;
                        end
                    end
                endcase
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            led_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            led_q   <= led_d;
            err_q   <= err_d;
        end
    end

    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;
    assign cpu.cpu_rdata = rdata_q;
    assign cpu.cpu_stall = cpu.cpu_req & ~cpu.cpu_ack;
    assign led_out       = led_q;
    assign bus_err       = err_q;

endmodule

// File: tb/tb_io_bus_ctrl.sv
// Directed bench for io_bus_ctrl with a timing/behaviour model checked every cycle.
module tb_io_bus_ctrl;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] sw_in;
    logic [15:0] led_out;
    logic        bus_err;

    io_cpu_if cpu_if ();
    io_mem_if mem_if ();

    io_bus_ctrl #(
        .MEM_LATENCY (LAT),
        .IO_BASE_HI  (22'h3FFFFF)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .cpu     (cpu_if),
        .mem     (mem_if),
        .sw_in   (sw_in),
        .led_out (led_out),
        .bus_err (bus_err)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    bit rst_edge = 1'b0;
    bit started = 1'b0;

    always @(posedge clk) begin
        cyc = cyc + 1;
        rst_edge = rst;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s (cycle %0d): got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    // Memory: reads answer exactly LAT cycles after the mem_en cycle, garbage otherwise.
    logic [31:0] mem_arr [logic [31:0]];
    int          resp_cyc = -1;
    logic [31:0] resp_data = '0;
    int          mem_en_cnt = 0;

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        return mem_arr.exists(a) ? mem_arr[a] : ~a;
    endfunction

    always @(negedge clk) begin
        if (mem_if.mem_en === 1'b1) begin
            mem_en_cnt++;
            if (mem_if.mem_we === 1'b1) begin
                mem_arr[mem_if.mem_addr] = mem_if.mem_wdata;
            end else begin
                resp_cyc  = cyc + LAT;
                resp_data = mem_read(mem_if.mem_addr);
            end
        end
        mem_if.mem_rdata = (cyc == resp_cyc) ? resp_data : 32'hBAD0_BAD0;
    end

    // Model of the externally visible behaviour, filled in per request.
    int          exp_ack_cyc = -1;
    int          exp_mem_cyc = -1;
    int          upd_addr_cyc = -1;
    bit          exp_mem_we = 1'b0;
    logic [31:0] m_rdata = '0, m_addr = '0, m_wdata = '0;
    logic [31:0] nx_addr = '0, nx_wdata = '0, upd_rdata = '0;
    logic [15:0] m_led = '0, upd_led = '0;
    bit          m_err = 1'b0, upd_err = 1'b0, upd_rdata_v = 1'b0, upd_led_v = 1'b0;

    always @(negedge clk) begin
        bit ack_e;
        bit en_e;
        if (rst_edge) begin
            started      = 1'b1;
            m_rdata      = '0;
            m_addr       = '0;
            m_wdata      = '0;
            m_led        = '0;
            m_err        = 1'b0;
            exp_ack_cyc  = -1;
            exp_mem_cyc  = -1;
            upd_addr_cyc = -1;
        end
        if (started) begin
            if (cyc == upd_addr_cyc) begin
                m_addr  = nx_addr;
                m_wdata = nx_wdata;
            end
            if (cyc == exp_ack_cyc) begin
                if (upd_rdata_v) m_rdata = upd_rdata;
                if (upd_led_v)   m_led   = upd_led;
                if (upd_err)     m_err   = 1'b1;
            end
            ack_e = (cyc == exp_ack_cyc);
            en_e  = (cyc == exp_mem_cyc);
            chk("cyc_ack",      32'(cpu_if.cpu_ack),   32'(ack_e));
            chk("cyc_stall",    32'(cpu_if.cpu_stall), 32'(cpu_if.cpu_req && !ack_e));
            chk("cyc_mem_en",   32'(mem_if.mem_en),    32'(en_e));
            chk("cyc_mem_we",   32'(mem_if.mem_we),    32'(en_e && exp_mem_we));
            chk("cyc_mem_addr", mem_if.mem_addr,       m_addr);
            chk("cyc_mem_wdata", mem_if.mem_wdata,     m_wdata);
            chk("cyc_rdata",    cpu_if.cpu_rdata,      m_rdata);
            chk("cyc_led",      32'(led_out),          32'(m_led));
            chk("cyc_bus_err",  32'(bus_err),          32'(m_err));
        end
    end

    task automatic start_access(input bit we, input logic [31:0] a, input logic [31:0] wd,
                                output int t_acc);
        bit io;
        t_acc = cyc;
        cpu_if.cpu_req   = 1'b1;
        cpu_if.cpu_we    = we;
        cpu_if.cpu_addr  = a;
        cpu_if.cpu_wdata = wd;
        io = (a[31:10] == 22'h3FFFFF);
        nx_addr      = a;
        nx_wdata     = wd;
        upd_addr_cyc = t_acc + 1;
        upd_rdata_v  = 1'b0;
        upd_led_v    = 1'b0;
        upd_err      = 1'b0;
        if (!io) begin
            exp_mem_cyc = t_acc + 1;
            exp_mem_we  = we;
            exp_ack_cyc = we ? t_acc + 2 : t_acc + 2 + LAT;
            if (!we) begin
                upd_rdata_v = 1'b1;
                upd_rdata   = mem_read(a);
            end
        end else begin
            exp_ack_cyc = t_acc + 2;
            if (a == 32'hFFFF_FC60) begin
                if (we) begin
                    upd_led_v = 1'b1;
                    upd_led   = wd[15:0];
                end else begin
                    upd_rdata_v = 1'b1;
                    upd_rdata   = {16'h0000, m_led};
                end
            end else if (a == 32'hFFFF_FC62) begin
                if (!we) begin
                    upd_rdata_v = 1'b1;
                    upd_rdata   = {16'h0000, sw_in};
                end
            end else begin
                upd_err = 1'b1;
                if (!we) begin
                    upd_rdata_v = 1'b1;
                    upd_rdata   = '0;
                end
            end
        end
    endtask

    task automatic finish_access(output logic [31:0] rd, output int t_ack);
        bit got;
        got   = 1'b0;
        t_ack = -1;
        rd    = '0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (cpu_if.cpu_ack === 1'b1) begin
                got   = 1'b1;
                t_ack = cyc;
                rd    = cpu_if.cpu_rdata;
            end
        end
        chk("ack_seen", 32'(got), 32'd1);
        @(posedge clk);
        #1;
        cpu_if.cpu_req = 1'b0;
    endtask

    task automatic access(input bit we, input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] rd, output int t_acc, output int t_ack);
        start_access(we, a, wd, t_acc);
        finish_access(rd, t_ack);
    endtask

    initial begin
        logic [31:0] rd;
        int ta, tk, ta1, ta2, en0, acks;

        cpu_if.cpu_req   = 1'b0;
        cpu_if.cpu_we    = 1'b0;
        cpu_if.cpu_addr  = '0;
        cpu_if.cpu_wdata = '0;
        sw_in            = '0;
        mem_arr[32'h0000_0100] = 32'hDEAD_BEEF;

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_rdata",    cpu_if.cpu_rdata,       32'h0);
        chk("rst_led",      32'(led_out),           32'h0);
        chk("rst_bus_err",  32'(bus_err),           32'h0);
        chk("rst_mem_en",   32'(mem_if.mem_en),     32'h0);
        chk("rst_ack",      32'(cpu_if.cpu_ack),    32'h0);
        @(posedge clk);
        #1;

        access(1'b0, 32'h0000_0100, 32'h0, rd, ta, tk);
        chk("memrd_ack_latency", 32'(tk - ta), 32'd4);
        chk("memrd_data",        rd,           32'hDEAD_BEEF);

        access(1'b1, 32'h0000_0040, 32'h1234_5678, rd, ta1, tk);
        chk("memwr_ack_latency", 32'(tk - ta1), 32'd2);
        chk("memwr_stored",      mem_read(32'h0000_0040), 32'h1234_5678);
        access(1'b1, 32'h0000_0044, 32'hCAFE_F00D, rd, ta2, tk);
        chk("b2b_write_spacing_1", 32'(ta2 - ta1), 32'd3);
        access(1'b1, 32'h0000_0048, 32'h0BAD_CAFE, rd, ta, tk);
        chk("b2b_write_spacing_2", 32'(ta - ta2), 32'd3);
        chk("rdata_held_after_writes", cpu_if.cpu_rdata, 32'hDEAD_BEEF);

        access(1'b0, 32'h0000_0044, 32'h0, rd, ta, tk);
        chk("memrd_back", rd, 32'hCAFE_F00D);

        en0 = mem_en_cnt;
        access(1'b1, 32'hFFFF_FC60, 32'h0000_A5A5, rd, ta, tk);
        chk("led_wr_ack_latency", 32'(tk - ta), 32'd2);
        chk("led_value",          32'(led_out), 32'h0000_A5A5);
        access(1'b0, 32'hFFFF_FC60, 32'h0, rd, ta, tk);
        chk("led_readback", rd, 32'h0000_A5A5);
        chk("io_no_mem_en", 32'(mem_en_cnt - en0), 32'd0);

        access(1'b1, 32'hFFFF_FC62, 32'h0000_FFFF, rd, ta, tk);
        chk("sw_write_ignored_led", 32'(led_out), 32'h0000_A5A5);
        chk("sw_write_no_err",      32'(bus_err), 32'h0);

        sw_in = 16'h00F0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        access(1'b0, 32'hFFFF_FC62, 32'h0, rd, ta, tk);
        chk("sw_read", rd, 32'h0000_00F0);

        access(1'b0, 32'hFFFF_FC70, 32'h0, rd, ta, tk);
        chk("unmapped_ack_latency", 32'(tk - ta), 32'd2);
        chk("unmapped_rdata",       rd,           32'h0);
        chk("unmapped_err",         32'(bus_err), 32'd1);
        access(1'b1, 32'h0000_0080, 32'h1111_2222, rd, ta, tk);
        chk("err_sticky", 32'(bus_err), 32'd1);

        start_access(1'b0, 32'h0000_0200, 32'h0, ta);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        cpu_if.cpu_req = 1'b0;
        @(negedge clk);
        chk("midrst_mem_en",   32'(mem_if.mem_en), 32'h0);
        chk("midrst_mem_addr", mem_if.mem_addr,    32'h0);
        chk("midrst_led",      32'(led_out),       32'h0);
        chk("midrst_err",      32'(bus_err),       32'h0);
        chk("midrst_rdata",    cpu_if.cpu_rdata,   32'h0);
        acks = (cpu_if.cpu_ack === 1'b1) ? 1 : 0;
        repeat (4) begin
            @(negedge clk);
            if (cpu_if.cpu_ack === 1'b1) acks++;
        end
        chk("midrst_no_ack", 32'(acks), 32'd0);
        @(posedge clk);
        #1;

        access(1'b0, 32'h0000_0100, 32'h0, rd, ta, tk);
        chk("post_rst_rd_latency", 32'(tk - ta), 32'd4);
        chk("post_rst_rd_data",    rd,           32'hDEAD_BEEF);
        access(1'b1, 32'hFFFF_FC64, 32'h0, rd, ta, tk);
        chk("unmapped_write_err",   32'(bus_err),     32'd1);
        chk("unmapped_write_rdata", cpu_if.cpu_rdata, 32'hDEAD_BEEF);

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: bench did not finish, %0d tests run", tests);
        $fatal(1);
    end

endmodule
